load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory block for the MIPS core with big-endian byte lanes. It executes
//   LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW/SWL/SWR. A request is taken with a
//   valid/ready handshake. After LATENCY clock edges a one-cycle response pulse
//   carries the load result and the address-error flag.
//
//   Optional feature: define LOAD_STORE_UNIT_ALIGN_CHECK_EN to flag misaligned
//   LH/LHU/SH (address[0]) and LW/SW (address[1:0]). A flagged access returns
//   exception=1 and read_data=0, and it does not write storage. When the macro
//   is undefined, exception is always 0.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous active-high reset
//   request_valid   request present
//   request_ready   unit can accept a request (high only in IDLE)
//   operation[3:0]  0 LB,1 LBU,2 LH,3 LHU,4 LW,5 LWL,6 LWR,8 SB,9 SH,10 SW,
//                   11 SWL,12 SWR; any other code is a no-op
//   address[31:0]   byte address; upper bits above the word index are ignored
//   write_data      rt value for stores
//   merge_data      old rt value for LWL/LWR
//   response_valid  one-cycle pulse; read_data/exception valid
//   read_data       load result (0 for stores and no-ops), held until next response
//   exception       address error, held until next response
module load_store_unit #(
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 1,
  parameter int ADDRESS_BITS = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic [3:0]  operation,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [31:0] merge_data,
  output logic        response_valid,
  output logic [31:0] read_data,
  output logic        exception
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;

  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              count_q, count_d;
  logic [3:0]              op_q, op_d;
  logic [ADDRESS_BITS+1:0] addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             merge_q, merge_d;
  logic [31:0]             read_data_q, read_data_d;
  logic                    exception_q, exception_d;

  logic [ADDRESS_BITS-1:0] word_index;
  logic [1:0]              byte_off;
  logic [4:0]              lsh;         // 8*n
  logic [4:0]              rsh;         // 8*(3-n)
  logic                    access_now;
  logic                    misaligned;
  logic [3:0]              store_be;    // bit k enables big-endian byte k
  logic [31:0]             store_word;
  logic [31:0]             mem_word;
  logic [31:0]             load_word;
  logic [15:0]             half_sel;
  logic [31:0]             byte_shifted;

  // Address bits above the word index wrap around.
  logic unused_address_bits;
  assign unused_address_bits = ^address[31:ADDRESS_BITS+2];

  assign word_index = addr_q[ADDRESS_BITS+1:2];
  assign byte_off   = addr_q[1:0];
  assign lsh        = {byte_off, 3'b000};
  assign rsh        = {2'd3 - byte_off, 3'b000};

  // The storage access happens on the edge that leaves WAIT. Reset forces
  // IDLE asynchronously, so an aborted store never reaches the array.
  assign access_now = (state_q == S_WAIT) && (count_q == 4'd0);

  // One byte-wide array per lane. Lane gi holds byte gi, which occupies bits
  // [31-8gi : 24-8gi] of the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clock) begin
      if (access_now && store_be[gi]) begin
        lane_mem[word_index] <= store_word[31-8*gi -: 8];
      end
    end

    assign mem_word[31-8*gi -: 8] = lane_mem[word_index];
  end

`ifdef LOAD_STORE_UNIT_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (op_q)
      OP_LH, OP_LHU, OP_SH: misaligned = byte_off[0];
      OP_LW, OP_SW:         misaligned = (byte_off != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Store lane placement and byte enables.
  always_comb begin
    store_be   = 4'b0000;
    store_word = 32'h0;
    case (op_q)
      OP_SB: begin
        store_be   = 4'b0001 << byte_off;
        store_word = {24'h0, wdata_q[7:0]} << rsh;
      end
      OP_SH: begin
        if (byte_off[1]) begin
          store_be   = 4'b1100;
          store_word = {16'h0, wdata_q[15:0]};
        end else begin
          store_be   = 4'b0011;
          store_word = {wdata_q[15:0], 16'h0};
        end
      end
      OP_SW: begin
        store_be   = 4'b1111;
        store_word = wdata_q;
      end
      OP_SWL: begin
        // Bytes n..3 receive the most significant bytes of rt.
        store_be   = 4'b1111 << byte_off;
        store_word = wdata_q >> lsh;
      end
      OP_SWR: begin
        // Bytes 0..n receive the least significant bytes of rt.
        store_be   = 4'b1111 >> (2'd3 - byte_off);
        store_word = wdata_q << rsh;
      end
      default: begin
        store_be   = 4'b0000;
        store_word = 32'h0;
      end
    endcase
    if (misaligned) begin
      store_be = 4'b0000;
    end
  end

  // Load result formatting.
  assign byte_shifted = mem_word >> rsh;
  assign half_sel     = byte_off[1] ? mem_word[15:0] : mem_word[31:16];

  always_comb begin
    load_word = 32'h0;
    case (op_q)
      OP_LB:  load_word = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
      OP_LBU: load_word = {24'h0, byte_shifted[7:0]};
      OP_LH:  load_word = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_word = {16'h0, half_sel};
      OP_LW:  load_word = mem_word;
      OP_LWL: load_word = (mem_word << lsh) | (merge_q & ((32'd1 << lsh) - 32'd1));
      OP_LWR: load_word = (mem_word >> rsh) | (merge_q & ~(32'hFFFF_FFFF >> rsh));
      default: load_word = 32'h0;
    endcase
    if (misaligned) begin
      load_word = 32'h0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    read_data_d = read_data_q;
    exception_d = exception_q;
    case (state_q)
      S_IDLE: begin
        if (request_valid) begin
          op_d    = operation;
          addr_d  = address[ADDRESS_BITS+1:0];
          wdata_d = write_data;
          merge_d = merge_data;
          count_d = COUNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (count_q == 4'd0) begin
          read_data_d = load_word;
          exception_d = misaligned;
          state_d     = S_RESPOND;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= 4'd0;
      op_q        <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      merge_q     <= 32'h0;
      read_data_q <= 32'h0;
      exception_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      read_data_q <= read_data_d;
      exception_q <= exception_d;
    end
  end

  assign request_ready  = (state_q == S_IDLE);
  assign response_valid = (state_q == S_RESPOND);
  assign read_data      = read_data_q;
  assign exception      = exception_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rv1, rv4;
  logic [3:0]  op;
  logic [31:0] addr, wd, md;
  logic        rdy1, rdy4, resp1, resp4, ex1, ex4;
  logic [31:0] rd1, rd4;

  // dut1: default depth and single-edge latency. dut4: small wrap-around
  // depth with a longer latency.
  load_store_unit #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clock(clk), .reset(rst), .request_valid(rv1), .request_ready(rdy1),
    .operation(op), .address(addr), .write_data(wd), .merge_data(md),
    .response_valid(resp1), .read_data(rd1), .exception(ex1));

  load_store_unit #(.DEPTH(16), .LATENCY(4)) dut4 (
    .clock(clk), .reset(rst), .request_valid(rv4), .request_ready(rdy4),
    .operation(op), .address(addr), .write_data(wd), .merge_data(md),
    .response_valid(resp4), .read_data(rd4), .exception(ex4));

  int checks = 0;
  int errors = 0;

  // Reference storage, one entry per byte address (big-endian within a word).
  logic [7:0] m1 [1024];
  logic [7:0] m4 [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic ready_of(input int sel);
    return (sel == 1) ? rdy1 : rdy4;
  endfunction
  function automatic logic resp_of(input int sel);
    return (sel == 1) ? resp1 : resp4;
  endfunction

  function automatic logic [7:0] mget(input int sel, input int idx);
    return (sel == 1) ? m1[idx] : m4[idx];
  endfunction
  task automatic mset(input int sel, input int idx, input logic [7:0] v);
    if (sel == 1) m1[idx] = v;
    else          m4[idx] = v;
  endtask

  // Behavioural model built from byte-level rules.
  task automatic model_op(input int sel, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] m,
                          output logic [31:0] r, output logic e);
    int nbytes;
    int base;
    int n;
    int h;
    logic [7:0] b [4];
    bit bad;
    nbytes = (sel == 1) ? 1024 : 64;
    base   = int'(a & 32'(nbytes - 1)) & ~3;
    n      = int'(a[1:0]);
    h      = n / 2;
    for (int i = 0; i < 4; i++) b[i] = mget(sel, base + i);
    r   = 32'h0;
    e   = 1'b0;
    bad = 1'b0;
`ifdef LOAD_STORE_UNIT_ALIGN_CHECK_EN
    if (((o == 4'd2 || o == 4'd3 || o == 4'd9) && (n % 2) != 0) ||
        ((o == 4'd4 || o == 4'd10) && n != 0)) bad = 1'b1;
`endif
    if (bad) begin
      e = 1'b1;
      return;
    end
    case (o)
      4'd0: r = {{24{b[n][7]}}, b[n]};
      4'd1: r = {24'h0, b[n]};
      4'd2: r = {{16{b[2*h][7]}}, b[2*h], b[2*h+1]};
      4'd3: r = {16'h0, b[2*h], b[2*h+1]};
      4'd4: r = {b[0], b[1], b[2], b[3]};
      4'd5: begin
        for (int i = 0; i < 4; i++) begin
          if (i <= 3 - n) r[31-8*i -: 8] = b[n+i];
          else            r[31-8*i -: 8] = m[31-8*i -: 8];
        end
      end
      4'd6: begin
        for (int i = 0; i < 4; i++) begin
          if (i >= 3 - n) r[31-8*i -: 8] = b[i-3+n];
          else            r[31-8*i -: 8] = m[31-8*i -: 8];
        end
      end
      4'd8: mset(sel, base + n, w[7:0]);
      4'd9: begin
        mset(sel, base + 2*h, w[15:8]);
        mset(sel, base + 2*h + 1, w[7:0]);
      end
      4'd10: for (int i = 0; i < 4; i++) mset(sel, base + i, w[31-8*i -: 8]);
      4'd11: for (int k = n; k < 4; k++) mset(sel, base + k, w[31-8*(k-n) -: 8]);
      4'd12: for (int k = 0; k <= n; k++) mset(sel, base + k, w[31-8*(3-n+k) -: 8]);
      default: ;
    endcase
  endtask

  // Performs one handshake on the selected unit and waits for its response.
  // Entered and left 1 time unit after a rising edge.
  task automatic access(input int sel, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] m,
                        output logic [31:0] r, output logic e);
    int waitc;
    int edges;
    int lat;
    lat   = (sel == 1) ? 1 : 4;
    waitc = 0;
    while (!ready_of(sel) && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (waitc >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    op = o; addr = a; wd = w; md = m;
    if (sel == 1) rv1 = 1'b1;
    else          rv4 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0; rv4 = 1'b0;
    // Scramble inputs: the unit must work from its latched copies.
    op = 4'($urandom); addr = $urandom; wd = $urandom; md = $urandom;
    edges = 0;
    while (!resp_of(sel) && edges < 40) begin
      check("ready_busy", {31'h0, ready_of(sel)}, 32'h0);
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, lat);
    check("ready_respond", {31'h0, ready_of(sel)}, 32'h0);
    r = (sel == 1) ? rd1 : rd4;
    e = (sel == 1) ? ex1 : ex4;
  endtask

  task automatic do_op(input int sel, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] m, input string tag,
                       output logic [31:0] r);
    logic [31:0] er;
    logic ee;
    logic e;
    model_op(sel, o, a, w, m, er, ee);
    access(sel, o, a, w, m, r, e);
    $display("op sel=%0d code=%0d addr=%h wd=%h md=%h rd=%h exc=%0b", sel, o, a, w, m, r, e);
    check({tag, "_rd"}, r, er);
    check({tag, "_exc"}, {31'h0, e}, {31'h0, ee});
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] m;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [20];

  initial begin
    logic [31:0] r;
    logic [31:0] er;
    logic e;
    logic ee;

    tv[0]  = '{4'd10, 32'h8, 32'h44556677, 32'h0,        32'h0};
    tv[1]  = '{4'd4,  32'h8, 32'h0,        32'h0,        32'h44556677};
    tv[2]  = '{4'd10, 32'h0, 32'hFFEE8899, 32'h0,        32'h0};
    tv[3]  = '{4'd0,  32'h0, 32'h0,        32'h0,        32'hFFFFFFFF};
    tv[4]  = '{4'd1,  32'h1, 32'h0,        32'h0,        32'h000000EE};
    tv[5]  = '{4'd2,  32'h2, 32'h0,        32'h0,        32'hFFFF8899};
    tv[6]  = '{4'd3,  32'h2, 32'h0,        32'h0,        32'h00008899};
    tv[7]  = '{4'd10, 32'h4, 32'h0,        32'h0,        32'h0};
    tv[8]  = '{4'd8,  32'h5, 32'h000000AB, 32'h0,        32'h0};
    tv[9]  = '{4'd9,  32'h6, 32'h0000CDEF, 32'h0,        32'h0};
    tv[10] = '{4'd4,  32'h4, 32'h0,        32'h0,        32'h00ABCDEF};
    tv[11] = '{4'd5,  32'h9, 32'h0,        32'hBB889977, 32'h55667777};
    tv[12] = '{4'd6,  32'h9, 32'h0,        32'hBB889977, 32'hBB884455};
    tv[13] = '{4'd11, 32'hA, 32'hAABBCCDD, 32'h0,        32'h0};
    tv[14] = '{4'd4,  32'h8, 32'h0,        32'h0,        32'h4455AABB};
    tv[15] = '{4'd12, 32'h1, 32'h11223344, 32'h0,        32'h0};
    tv[16] = '{4'd4,  32'h0, 32'h0,        32'h0,        32'h33448899};
    tv[17] = '{4'd7,  32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    tv[18] = '{4'd15, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    tv[19] = '{4'd4,  32'h0, 32'h0,        32'h0,        32'h33448899};

    // Reset state.
    rst = 1'b1; rv1 = 1'b0; rv4 = 1'b0; op = 4'h0; addr = 32'h0; wd = 32'h0; md = 32'h0;
    #12;
    check("reset_ready1", {31'h0, rdy1}, 32'h1);
    check("reset_ready4", {31'h0, rdy4}, 32'h1);
    check("reset_resp1", {31'h0, resp1}, 32'h0);
    check("reset_rd1", rd1, 32'h0);
    check("reset_exc1", {31'h0, ex1}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Give every word a known value.
    for (int i = 0; i < 256; i++) do_op(1, 4'd10, 32'(i * 4), $urandom, 32'h0, "init1", r);
    for (int i = 0; i < 16; i++)  do_op(4, 4'd10, 32'(i * 4), $urandom, 32'h0, "init4", r);

    // Directed vector table on dut1.
    for (int i = 0; i < 20; i++) begin
      model_op(1, tv[i].op, tv[i].a, tv[i].w, tv[i].m, er, ee);
      access(1, tv[i].op, tv[i].a, tv[i].w, tv[i].m, r, e);
      $display("vec %0d code=%0d addr=%h rd=%h exp=%h exc=%0b", i, tv[i].op, tv[i].a, r, tv[i].exp, e);
      check($sformatf("vec%0d_rd", i), r, tv[i].exp);
      check($sformatf("vec%0d_exc", i), {31'h0, e}, 32'h0);
    end

    // Outputs hold after the response pulse drops.
    @(posedge clk); #1;
    check("hold_resp", {31'h0, resp1}, 32'h0);
    check("hold_rd", rd1, 32'h33448899);

    // Misaligned word store.
    do_op(1, 4'd10, 32'h13, 32'h11111111, 32'h0, "mis_sw", r);
`ifdef LOAD_STORE_UNIT_ALIGN_CHECK_EN
    check("mis_sw_exc_flag", {31'h0, ex1}, 32'h1);
    do_op(1, 4'd4, 32'h10, 32'h0, 32'h0, "mis_lw", r);
`else
    check("mis_sw_exc_flag", {31'h0, ex1}, 32'h0);
    do_op(1, 4'd4, 32'h10, 32'h0, 32'h0, "mis_lw", r);
    check("mis_lw_word", r, 32'h11111111);
`endif

    // Reset in the middle of a LATENCY=4 store.
    do_op(4, 4'd10, 32'h10, 32'hCAFEF00D, 32'h0, "pre_sw", r);
    do_op(4, 4'd4, 32'h10, 32'h0, 32'h0, "pre_lw", r);
    while (!rdy4) begin @(posedge clk); #1; end
    op = 4'd10; addr = 32'h10; wd = 32'h12345678; md = 32'h0; rv4 = 1'b1;
    @(posedge clk); #1;
    rv4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    $display("abort reset rd4=%h resp4=%0b rdy4=%0b", rd4, resp4, rdy4);
    check("abort_rd4", rd4, 32'h0);
    check("abort_resp4", {31'h0, resp4}, 32'h0);
    check("abort_ready4", {31'h0, rdy4}, 32'h1);
    check("abort_rd1", rd1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(4, 4'd4, 32'h10, 32'h0, 32'h0, "post_lw", r);
    check("post_lw_old", r, 32'hCAFEF00D);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = ($urandom_range(0, 1) == 0) ? 1 : 4;
      do_op(sel, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, "rand", r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
